// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the datapath blocks.
//   OP_DIV       - DIV instruction opcode.
//   DIV_WIDTH    - default operand/result width of the divider.
//   ST_*         - divider FSM encodings, also used for the enum values so
//                  legacy code that compares against raw 2-bit codes agrees.
//   div_state_e  - divider FSM state type (exposed on the divider's state port).
package cpu_pkg;

  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam int         DIV_WIDTH = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    DIV_IDLE  = ST_IDLE,
    DIV_RUN   = ST_RUN,
    DIV_FIXUP = ST_FIXUP,
    DIV_DONE  = ST_DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration, purely combinational.
//   r_in  - partial remainder (always < divisor magnitude, so WIDTH bits hold it)
//   q_in  - dividend/quotient shift register
//   dvs   - divisor magnitude (unsigned; 2^(WIDTH-1) is a legal value)
//   r_out - next partial remainder
//   q_out - next shift register, new quotient bit in bit 0
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  // The shifted remainder needs WIDTH+1 bits so a 2^(WIDTH-1) divisor
  // magnitude compares exactly.
  logic [WIDTH:0] r_shift;
  logic           ge;

  assign r_shift = {r_in, q_in[WIDTH-1]};
  assign ge      = (r_shift >= {1'b0, dvs});

  // When ge holds the true difference is below the divisor, so the low
  // WIDTH bits of a modular subtract are exact.
  assign r_out = ge ? (r_shift[WIDTH-1:0] - dvs) : r_shift[WIDTH-1:0];
  assign q_out = {q_in[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed divider, one quotient bit per clock.
//   clock       - rising-edge clock
//   clear       - asynchronous active-low reset
//   start       - request, sampled only in IDLE or DONE
//   dividend    - signed dividend
//   divisor     - signed divisor
//   busy        - high in RUN and FIXUP
//   done        - one-cycle pulse, results valid
//   quotient    - signed quotient (truncated toward zero)
//   remainder   - signed remainder, sign of the dividend
//   div_by_zero - set with done when the divisor was zero
//   state       - current FSM state (debug)
//
// Handshake: start is accepted on a rising edge when the FSM is in IDLE or
// DONE; operands are captured on that edge and later changes are ignored.
// busy covers the whole computation; done pulses for exactly one cycle and
// results then hold until the next accepted start. start during busy is
// ignored. Holding start in DONE begins the next division with no idle gap.
module seq_divider
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_e       state
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_q, q_q, dvs_q;
  logic [WIDTH-1:0] r_next, q_next;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r;
  logic             accept;

  assign accept       = start && ((state == DIV_IDLE) || (state == DIV_DONE));
  // Magnitudes as unsigned values: the most negative input maps to
  // 2^(WIDTH-1), which is exactly representable unsigned.
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

  assign busy = (state == DIV_RUN) || (state == DIV_FIXUP);
  assign done = (state == DIV_DONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .dvs   (dvs_q),
    .r_out (r_next),
    .q_out (q_next)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= DIV_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE, DIV_DONE: begin
          if (accept) begin
            if (divisor == '0) begin
              // No iteration needed: report immediately.
              state       <= DIV_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= DIV_RUN;
              r_q         <= '0;
              q_q         <= dividend_mag;
              dvs_q       <= divisor_mag;
              sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r      <= dividend[WIDTH-1];
              count       <= '0;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= DIV_IDLE;
          end
        end
        DIV_RUN: begin
          r_q   <= r_next;
          q_q   <= q_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= DIV_FIXUP;
        end
        DIV_FIXUP: begin
          // Negation is modulo 2^WIDTH, so MIN / -1 yields MIN with no trap.
          quotient  <= sign_q ? -q_q : q_q;
          remainder <= sign_r ? -r_q : r_q;
          state     <= DIV_DONE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  import cpu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  div_state_e   state;

  always #5 clock = ~clock;

  seq_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state       (state)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {div_by_zero, remainder, quotient}
  logic [2*W:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] qq, rr;
    logic         z;
    if (b == '0) begin
      qq = '1; rr = a; z = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      qq = 32'h8000_0000; rr = '0; z = 1'b0;
    end else begin
      qq = $signed(a) / $signed(b);
      rr = $signed(a) % $signed(b);
      z  = 1'b0;
    end
    return {z, rr, qq};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; start is accepted on the following posedge.
  task automatic drive_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q.push_back(model(a, b));
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Counts negedges until done; returns lat=-1 on timeout.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      lat++;
      if (busy) bcnt++;
      if (done) return;
    end
    checks++; failures++;
    $display("FAIL wait_done timeout: done not seen within 200 cycles");
    lat = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== '0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== '0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    checks++; if (state !== DIV_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic [2*W:0] e;
    drive_div(32'd100, 32'd7);
    wait_done(lat, bcnt);
    e = exp_q.pop_front();
    checks++; if (lat !== 34) begin failures++; $display("FAIL basic_latency got=%0d exp=34", lat); end
    checks++; if (bcnt !== 33) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=33", bcnt); end
    checks++; if (quotient !== e[W-1:0]) begin failures++; $display("FAIL basic_quotient got=%h exp=%h", quotient, e[W-1:0]); end
    checks++; if (remainder !== e[2*W-1:W]) begin failures++; $display("FAIL basic_remainder got=%h exp=%h", remainder, e[2*W-1:W]); end
    checks++; if (div_by_zero !== e[2*W]) begin failures++; $display("FAIL basic_dbz got=%b exp=%b", div_by_zero, e[2*W]); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (state !== DIV_IDLE) begin failures++; $display("FAIL basic_return_idle got=%0d exp=0", state); end
    checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL basic_hold_quotient got=%h exp=e", quotient); end
  endtask

  task automatic test_signs();
    logic [W-1:0] as_[4] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000};
    logic [W-1:0] bs_[4] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    int lat, bcnt;
    logic [2*W:0] e;
    logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        a = as_[i]; b = bs_[i];
      end else begin
        a = $urandom;
        b = (i % 2 == 0) ? $urandom : W'($urandom_range(1, 300));
        if (b == '0) b = 32'd3;
      end
      drive_div(a, b);
      wait_done(lat, bcnt);
      e = exp_q.pop_front();
      checks++; if (quotient !== e[W-1:0]) begin failures++; $display("FAIL signs_quotient[%0d] a=%h b=%h got=%h exp=%h", i, a, b, quotient, e[W-1:0]); end
      checks++; if (remainder !== e[2*W-1:W]) begin failures++; $display("FAIL signs_remainder[%0d] a=%h b=%h got=%h exp=%h", i, a, b, remainder, e[2*W-1:W]); end
      checks++; if (div_by_zero !== e[2*W]) begin failures++; $display("FAIL signs_dbz[%0d] got=%b exp=%b", i, div_by_zero, e[2*W]); end
      @(negedge clock);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    logic [2*W:0] e;
    drive_div(32'd55, 32'd0);
    wait_done(lat, bcnt);
    e = exp_q.pop_front();
    checks++; if (lat !== 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    checks++; if (bcnt !== 0) begin failures++; $display("FAIL dbz_busy_cycles got=%0d exp=0", bcnt); end
    checks++; if (quotient !== e[W-1:0]) begin failures++; $display("FAIL dbz_quotient got=%h exp=%h", quotient, e[W-1:0]); end
    checks++; if (remainder !== e[2*W-1:W]) begin failures++; $display("FAIL dbz_remainder got=%h exp=%h", remainder, e[2*W-1:W]); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [2*W:0] e;
    drive_div(32'd100, 32'd7);
    repeat (9) @(negedge clock);
    // Stray request mid-run must be ignored (no expectation pushed).
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clock);
    #1 start = 1'b0; dividend = 32'd1; divisor = 32'd1;
    wait_done(lat, bcnt);
    e = exp_q.pop_front();
    checks++; if (quotient !== e[W-1:0]) begin failures++; $display("FAIL b2b_ignore_quotient got=%h exp=%h", quotient, e[W-1:0]); end
    checks++; if (remainder !== e[2*W-1:W]) begin failures++; $display("FAIL b2b_ignore_remainder got=%h exp=%h", remainder, e[2*W-1:W]); end
    // Start presented during the DONE cycle.
    drive_div(32'd9, 32'd3);
    @(negedge clock);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_single got=%b exp=0", done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble got=%b exp=1", busy); end
    wait_done(lat, bcnt);
    e = exp_q.pop_front();
    checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    checks++; if (quotient !== e[W-1:0]) begin failures++; $display("FAIL b2b_quotient got=%h exp=%h", quotient, e[W-1:0]); end
    checks++; if (remainder !== e[2*W-1:W]) begin failures++; $display("FAIL b2b_remainder got=%h exp=%h", remainder, e[2*W-1:W]); end
    @(negedge clock);
  endtask

  task automatic test_clear_mid_run();
    int lat, bcnt;
    logic [2*W:0] e;
    drive_div(32'd100, 32'd7);
    repeat (15) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL clr_done got=%b exp=0", done); end
    checks++; if (quotient !== '0) begin failures++; $display("FAIL clr_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== '0) begin failures++; $display("FAIL clr_remainder got=%h exp=0", remainder); end
    checks++; if (state !== DIV_IDLE) begin failures++; $display("FAIL clr_state got=%0d exp=0", state); end
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    drive_div(32'd20, 32'd6);
    wait_done(lat, bcnt);
    e = exp_q.pop_front();
    checks++; if (lat !== 34) begin failures++; $display("FAIL clr_fresh_latency got=%0d exp=34", lat); end
    checks++; if (quotient !== e[W-1:0]) begin failures++; $display("FAIL clr_fresh_quotient got=%h exp=%h", quotient, e[W-1:0]); end
    checks++; if (remainder !== e[2*W-1:W]) begin failures++; $display("FAIL clr_fresh_remainder got=%h exp=%h", remainder, e[2*W-1:W]); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL clr_fresh_dbz got=%b exp=0", div_by_zero); end
    @(negedge clock);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_back_to_back();
    test_clear_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle signed 32-bit divider for the datapath's DIV instruction (opcode 5'b10000). Sits directly upstream of the ALU's Z-output stage: the ALU issues operands A (dividend) and B (divisor) and consumes the quotient into Zlow and the remainder into Zhigh. One quotient bit is retired per clock with a start/busy/done handshake, so a combinational 32-bit divider is no longer needed in the critical path.

## Interface
- WIDTH, 32, operand/result width; all widths below scale with it.
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- dividend  in  WIDTH  signed dividend (ALU A).
- divisor  in  WIDTH  signed divisor (ALU B).
- busy  out  1  high in RUN and FIXUP.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  signed quotient, drives ALU Zlow.
- remainder  out  WIDTH  signed remainder, drives ALU Zhigh.
- div_by_zero  out  1  set with done when divisor was 0.

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- IDLE/DONE + start, divisor≠0:
  - latch |dividend| and |divisor|.
  - latch sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - clear partial remainder; count=0; go to RUN.
- IDLE/DONE + start, divisor=0:
  - go to DONE directly.
  - quotient=all ones, remainder=dividend, div_by_zero=1.
- RUN, restoring step per cycle:
  - R' = {R[W-2:0], Q[W-1]}, Q shifted left.
  - if R' ≥ |divisor|: R=R'−|divisor|, Q[0]=1; else R=R', Q[0]=0.
  - count increments; after WIDTH steps go to FIXUP.
- Partial remainder is WIDTH+1 bits so the 0x80000000 magnitude (2^31 unsigned) is exact.
- FIXUP:
  - quotient = sign_q ? −Q : Q; remainder = sign_r ? −R : R; mod 2^WIDTH.
  - go to DONE.
- DONE: done=1 for exactly one cycle; next state IDLE unless start re-accepted.
- Semantics: truncation toward zero; remainder takes dividend's sign; dividend = q·divisor + r.
- Overflow 0x80000000 / −1: quotient=0x80000000, remainder=0, div_by_zero=0; no trap.
- start in RUN/FIXUP ignored; operand changes after acceptance ignored.
- quotient/remainder/div_by_zero hold until the next accepted start.
- div_by_zero clears on next accepted start.

## Timing
- clear low (async, any state including mid-RUN): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
- Normal latency, start accepted at edge 0:
  - RUN iterations at edges 1..WIDTH.
  - FIXUP registers results at edge WIDTH+1 (33).
  - done high in the cycle following edge 33.
  - 34 cycles start→done for WIDTH=32.
- busy high from the cycle after edge 0 through edge 33.
- Divide-by-zero latency: 1 cycle; busy never asserts.
- Back-to-back: start held high in DONE is accepted; done pulses for one cycle only, with no IDLE bubble.

## Structure
- Shared package cpu_pkg:
  - DIV opcode constant 5'b10000.
  - divider state enum (IDLE, RUN, FIXUP, DONE).
  - WIDTH default.
- One natural sub-module, div_step: combinational single restoring iteration (R, Q, divisor in → R', Q' out), instantiated once in seq_divider.
- Counter width $clog2(WIDTH)+1.

## Test plan
- 100 / 7 → quotient=14, remainder=2, done exactly 34 cycles after start, busy high 33 cycles.
- −100 / 7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; 100 / −7 → quotient=0xFFFFFFF2, remainder=2.
- 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, div_by_zero=0.
- 55 / 0 → next cycle done=1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=55, busy never high.
- Second start with 9/3 pulsed at cycle 10 of a 100/7 run → ignored, result 14/2; then 9/3 accepted from DONE → quotient=3, remainder=0.
- clear low at cycle 15 of a run → all outputs 0 immediately; fresh 20/6 afterwards → quotient=3, remainder=2.
